// File: rtl/cordic_pre_stage.sv
`timescale 1ns/1ps
// CORDIC pre-processor: angle range reduction, quadrant fold and mode-dependent start
// vector generation in a two-stage valid/ready pipeline ahead of the iteration core.
module cordic_pre_stage #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [W-1:0]     out_z,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_quad,
  output logic             out_wrap,
  output logic             out_err
);

  // Constants are specified at W=32 and rescaled so the fixed-point format tracks W.
  function automatic logic [W-1:0] scale_const(input logic [31:0] c);
    logic signed [95:0] v;
    int                 sh;
    v  = $signed({64'd0, c});
    sh = int'(W) - 32;
    if (sh >= 0) v = v <<< sh;
    else         v = v >>> (-sh);
    return v[W-1:0];
  endfunction

  // Results of the 2pi correction always fit in W bits, so modulo-2^W arithmetic on the
  // low W bits of TWO_PI gives the same truncated value as the W+1-bit form.
  localparam logic signed [W-1:0] Pi     = scale_const(32'h6487ED51);
  localparam logic signed [W-1:0] NegPi  = -Pi;
  localparam logic signed [W-1:0] Pi2    = scale_const(32'h3243F6A9);
  localparam logic signed [W-1:0] NegPi2 = -Pi2;
  localparam logic        [W-1:0] TwoPi  = scale_const(32'hC90FDAA2);
  localparam logic        [W-1:0] KCirc  = scale_const(32'h13510BD6);
  localparam logic        [W-1:0] NegK   = -KCirc;
  localparam logic        [W-1:0] KHyp   = scale_const(32'h26902DE0);
  localparam logic        [W-1:0] SqOff  = scale_const(32'h20000000);
  localparam logic        [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
  localparam logic        [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] sat(input logic [W:0] v);
    if (v[W] != v[W-1]) return v[W] ? SatMin : SatMax;
    return v[W-1:0];
  endfunction

  // Stage 1 state
  logic             s1_valid_q;
  logic [1:0]       s1_mode_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [W-1:0]     s1_z_q;
  logic             s1_wrap_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q;
  logic [W-1:0]     s2_x_q, s2_y_q, s2_z_q;
  logic [1:0]       s2_mode_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [1:0]       s2_quad_q;
  logic             s2_wrap_q, s2_err_q;

  logic s2_ready;

  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  // Stage 1: range reduction for rotation modes only
  logic [W-1:0] z1;
  logic         wrap1;

  always_comb begin
    z1    = in_x;
    wrap1 = 1'b0;
    if (!in_mode[0]) begin
      if ($signed(in_x) > Pi) begin
        z1    = in_x - TwoPi;
        wrap1 = 1'b1;
      end else if ($signed(in_x) < NegPi) begin
        z1    = in_x + TwoPi;
        wrap1 = 1'b1;
      end
    end
  end

  // Stage 2: start vector generation
  logic [W:0]   sum_h, dif_h;
  logic [W-1:0] x2, y2, z2;
  logic [1:0]   quad2;
  logic         err2;

  always_comb begin
    x2    = '0;
    y2    = '0;
    z2    = '0;
    quad2 = 2'b00;
    err2  = 1'b0;
    sum_h = {s1_z_q[W-1], s1_z_q} + {1'b0, SqOff};
    dif_h = {s1_z_q[W-1], s1_z_q} - {1'b0, SqOff};
    unique case (s1_mode_q)
      2'b00: begin
        if ($signed(s1_z_q) > Pi2) begin
          y2    = KCirc;
          z2    = s1_z_q - Pi2;
          quad2 = 2'b01;
        end else if ($signed(s1_z_q) < NegPi2) begin
          y2    = NegK;
          z2    = s1_z_q + Pi2;
          quad2 = 2'b10;
        end else begin
          x2 = KCirc;
          z2 = s1_z_q;
        end
      end
      2'b01: begin
        x2 = SqOff;
        y2 = s1_z_q;
      end
      2'b10: begin
        x2 = KHyp;
        z2 = s1_z_q;
      end
      2'b11: begin
        x2   = sat(sum_h);
        y2   = sat(dif_h);
        err2 = s1_z_q[W-1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      s1_tag_q   <= '0;
      s1_z_q     <= '0;
      s1_wrap_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_z_q     <= '0;
      s2_mode_q  <= '0;
      s2_tag_q   <= '0;
      s2_quad_q  <= '0;
      s2_wrap_q  <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mode_q <= in_mode;
          s1_tag_q  <= in_tag;
          s1_z_q    <= z1;
          s1_wrap_q <= wrap1;
        end
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_x_q    <= x2;
          s2_y_q    <= y2;
          s2_z_q    <= z2;
          s2_mode_q <= s1_mode_q;
          s2_tag_q  <= s1_tag_q;
          s2_quad_q <= quad2;
          s2_wrap_q <= s1_wrap_q;
          s2_err_q  <= err2;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_x     = s2_x_q;
  assign out_y     = s2_y_q;
  assign out_z     = s2_z_q;
  assign out_mode  = s2_mode_q;
  assign out_tag   = s2_tag_q;
  assign out_quad  = s2_quad_q;
  assign out_wrap  = s2_wrap_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_cordic_pre_stage.sv
`timescale 1ns/1ps
// Self-checking bench for cordic_pre_stage at W=32 and W=24 against a longint model.
module tb_cordic_pre_stage;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [1:0]  mode;
    logic [3:0]  tag;
    logic [1:0]  quad;
    logic        wrap;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode, out_mode, out_quad;
  logic [31:0] in_x, out_x, out_y, out_z;
  logic [3:0]  in_tag, out_tag;
  logic        out_wrap, out_err;

  logic        v24_in_valid, v24_in_ready, v24_out_valid, v24_out_ready;
  logic [1:0]  v24_in_mode, v24_out_mode, v24_out_quad;
  logic [23:0] v24_in_x, v24_out_x, v24_out_y, v24_out_z;
  logic [3:0]  v24_in_tag, v24_out_tag;
  logic        v24_out_wrap, v24_out_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  cordic_pre_stage #(.W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_mode(out_mode), .out_tag(out_tag),
    .out_quad(out_quad), .out_wrap(out_wrap), .out_err(out_err)
  );

  cordic_pre_stage #(.W(24), .TAG_W(4)) dut24 (
    .clk(clk), .rst(rst), .in_valid(v24_in_valid), .in_ready(v24_in_ready),
    .in_mode(v24_in_mode), .in_x(v24_in_x), .in_tag(v24_in_tag),
    .out_valid(v24_out_valid), .out_ready(v24_out_ready), .out_x(v24_out_x),
    .out_y(v24_out_y), .out_z(v24_out_z), .out_mode(v24_out_mode), .out_tag(v24_out_tag),
    .out_quad(v24_out_quad), .out_wrap(v24_out_wrap), .out_err(v24_out_err)
  );

  function automatic longint scale(int w, longint c);
    if (w >= 32) return c << (w - 32);
    return c >> (32 - w);
  endfunction

  function automatic logic [31:0] wbits(int w, longint v);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    return m[31:0];
  endfunction

  // Reference: plain signed arithmetic on the rules, then wrapped to w bits.
  function automatic exp_t model(int w, logic [1:0] mode, logic [31:0] xin, logic [3:0] tag);
    exp_t   e;
    longint x, z1, pi, pi2, tpi, k, kh, sq, hi, lo, ox, oy, oz;
    pi  = scale(w, 64'h6487ED51);
    pi2 = scale(w, 64'h3243F6A9);
    tpi = scale(w, 64'hC90FDAA2);
    k   = scale(w, 64'h13510BD6);
    kh  = scale(w, 64'h26902DE0);
    sq  = scale(w, 64'h20000000);
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    x   = longint'(xin) & ((longint'(1) << w) - 1);
    if (x > hi) x = x - (longint'(1) << w);
    e   = '0;
    z1  = x;
    if (mode == 2'b00 || mode == 2'b10) begin
      if (x > pi)       begin z1 = x - tpi; e.wrap = 1'b1; end
      else if (x < -pi) begin z1 = x + tpi; e.wrap = 1'b1; end
    end
    ox = 0; oy = 0; oz = 0;
    case (mode)
      2'b00: begin
        if (z1 > pi2)       begin oy = k;  oz = z1 - pi2; e.quad = 2'b01; end
        else if (z1 < -pi2) begin oy = -k; oz = z1 + pi2; e.quad = 2'b10; end
        else                begin ox = k;  oz = z1; end
      end
      2'b01: begin ox = sq; oy = x; end
      2'b10: begin ox = kh; oz = z1; end
      default: begin
        ox = x + sq;
        oy = x - sq;
        if (ox > hi) ox = hi;
        if (oy < lo) oy = lo;
        e.err = (x < 0);
      end
    endcase
    e.x    = wbits(w, ox);
    e.y    = wbits(w, oy);
    e.z    = wbits(w, oz);
    e.mode = mode;
    e.tag  = tag;
    return e;
  endfunction

  function automatic logic [31:0] pick_x();
    case ($urandom_range(0, 7))
      0: return 32'h6487ED51;
      1: return 32'h9B7812AF;
      2: return 32'h6487ED52;
      3: return 32'h3243F6A9;
      4: return 32'hCDBC0957;
      default: return $urandom();
    endcase
  endfunction

  task automatic idle();
    in_valid = 1'b0; in_mode = 2'b00; in_x = '0; in_tag = '0; out_ready = 1'b1;
    v24_in_valid = 1'b0; v24_in_mode = 2'b00; v24_in_x = '0; v24_in_tag = '0;
    v24_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {out_x, out_y, out_z, out_mode, out_tag, out_quad, out_wrap, out_err};
    n_checks++;
    if (out_valid !== 1'b0 || v24_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b/%b want=0/0", out_valid, v24_out_valid);
    end
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", got); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] dx [10];
    logic [1:0]  dm [10];
    exp_t        e, got;
    int          lat;
    dx = '{32'h40000000, 32'h70000000, 32'h6487ED51, 32'h3243F6A9, 32'h10000000,
           32'h70000000, 32'hF0000000, 32'h9B7812AF, 32'h12345678, 32'h80000000};
    dm = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = dm[i]; in_x = dx[i]; in_tag = 4'(i); out_ready = 1'b1;
      e = model(32, dm[i], dx[i], 4'(i));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 6) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL latency[%0d] got=%0d want=2", i, lat); end
      got = {out_x, out_y, out_z, out_mode, out_tag, out_quad, out_wrap, out_err};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL directed[%0d] got=%h want=%h", i, got, e); end
      n_checks++;
      case (i)
        0: if ({out_x, out_y, out_z, out_quad, out_wrap} !==
               {32'h0, 32'h13510BD6, 32'h0DBC0957, 2'b01, 1'b0}) begin
             n_fail++; $display("FAIL fold_q1 got=%h %h %h %b %b want=0 13510bd6 0dbc0957 01 0",
                                out_x, out_y, out_z, out_quad, out_wrap);
           end
        1: if ({out_x, out_y, out_z, out_quad, out_wrap} !==
               {32'h0, 32'hECAEF42A, 32'hD9341C07, 2'b10, 1'b1}) begin
             n_fail++; $display("FAIL wrap_fold got=%h %h %h %b %b want=0 ecaef42a d9341c07 10 1",
                                out_x, out_y, out_z, out_quad, out_wrap);
           end
        2: if ({out_wrap, out_quad} !== 3'b001) begin
             n_fail++; $display("FAIL pi_edge got=%b%b want=001", out_wrap, out_quad);
           end
        3: if ({out_quad, out_z} !== {2'b00, 32'h3243F6A9}) begin
             n_fail++; $display("FAIL pi2_edge got=%b %h want=00 3243f6a9", out_quad, out_z);
           end
        4: if ({out_x, out_y, out_err} !== {32'h30000000, 32'hF0000000, 1'b0}) begin
             n_fail++; $display("FAIL sqrt_vec got=%h %h %b want=30000000 f0000000 0",
                                out_x, out_y, out_err);
           end
        5: if (out_x !== 32'h7FFFFFFF) begin
             n_fail++; $display("FAIL sqrt_sat got=%h want=7fffffff", out_x);
           end
        6: if (out_err !== 1'b1) begin n_fail++; $display("FAIL sqrt_err got=%b want=1", out_err); end
        default: if (out_tag !== 4'(i)) begin
             n_fail++; $display("FAIL tag[%0d] got=%h want=%h", i, out_tag, 4'(i));
           end
      endcase
    end
  endtask

  task automatic test_w24();
    logic [23:0] dx [4];
    logic [1:0]  dm [4];
    exp_t        e, got;
    int          lat;
    dx = '{24'h400000, 24'h700000, 24'h6487ED, 24'h900000};
    dm = '{2'b00, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v24_in_valid = 1'b1; v24_in_mode = dm[i]; v24_in_x = dx[i]; v24_in_tag = 4'(i);
      e = model(24, dm[i], {8'h0, dx[i]}, 4'(i));
      @(posedge clk); #1;
      v24_in_valid = 1'b0;
      lat = 1;
      while (!v24_out_valid && lat < 6) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL w24_latency[%0d] got=%0d want=2", i, lat); end
      got = {8'h0, v24_out_x, 8'h0, v24_out_y, 8'h0, v24_out_z, v24_out_mode, v24_out_tag,
             v24_out_quad, v24_out_wrap, v24_out_err};
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL w24[%0d] got=%h want=%h", i, got, e); end
      if (i == 0) begin
        n_checks++;
        if ({v24_out_x, v24_out_y, v24_out_z, v24_out_quad} !==
            {24'h0, 24'h13510B, 24'h0DBC0A, 2'b01}) begin
          n_fail++; $display("FAIL w24_fold got=%h %h %h %b want=0 13510b 0dbc0a 01",
                             v24_out_x, v24_out_y, v24_out_z, v24_out_quad);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [8];
    logic [1:0]  ms [8];
    exp_t        e, got, prev;
    int          sent, recv;
    bit          prev_stalled;
    for (int i = 0; i < 8; i++) begin xs[i] = pick_x(); ms[i] = 2'($urandom_range(0, 3)); end
    sent = 0; recv = 0; prev_stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin in_x = xs[sent]; in_mode = ms[sent]; in_tag = 4'(sent); end
      #1;
      got = {out_x, out_y, out_z, out_mode, out_tag, out_quad, out_wrap, out_err};
      if (prev_stalled) begin
        n_checks++;
        if (got !== prev || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_hold got=%h want=%h", got, prev);
        end
      end
      if (cyc >= 3 && cyc < 6) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
      end
      if (cyc == 6) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra got=%h want=none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e || out_tag !== 4'(recv)) begin
            n_fail++; $display("FAIL b2b[%0d] got=%h want=%h", recv, got, e);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin sb.push_back(model(32, in_mode, in_x, in_tag)); sent++; end
      prev_stalled = out_valid && !out_ready;
      prev = got;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv != 8 || sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_count got=%0d left=%0d want=8 left=0", recv, sb.size());
    end
  endtask

  task automatic test_random();
    exp_t e, got;
    bit   have;
    int   seen;
    have = 1'b0; seen = 0;
    for (int cyc = 0; cyc < 410; cyc++) begin
      @(negedge clk);
      if (cyc < 400 && !have && $urandom_range(0, 3) != 0) begin
        have = 1'b1; in_x = pick_x(); in_mode = 2'($urandom_range(0, 3)); in_tag = 4'($urandom());
      end
      in_valid  = have;
      out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got = {out_x, out_y, out_z, out_mode, out_tag, out_quad, out_wrap, out_err};
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_extra got=%h want=none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL rand[%0d] got=%h want=%h", seen, got, e); end
        end
        seen++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(32, in_mode, in_x, in_tag));
        have = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain got=%0d left want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    exp_t got;
    int   cnt;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_x = 32'h40000000; in_tag = 4'hA;
    @(negedge clk);
    in_tag = 4'hB;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_setup got=%b%b want=10", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    got = {out_x, out_y, out_z, out_mode, out_tag, out_quad, out_wrap, out_err};
    n_checks++;
    if (out_valid !== 1'b0 || got !== '0) begin
      n_fail++; $display("FAIL rst_flush got=%b %h want=0 0", out_valid, got);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) cnt++; end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL rst_stale got=%0d want=0", cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_directed();
    test_w24();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
